cheshire_rtc_rst_gen: RTL and testbench

CHESHIRE_RTC_RST_GEN -- requirements
Module: cheshire_rtc_rst_gen

---
 rtl/cheshire_fpga_pkg.sv | 31 +++
 rtl/cheshire_rtc_rst_gen_if.sv | 22 ++
 rtl/cheshire_rst_debounce.sv | 39 +++
 rtl/cheshire_rtc_rst_gen.sv | 131 +++++++++++++
 tb/tb_cheshire_rtc_rst_gen.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/cheshire_fpga_pkg.sv
// Shared definitions for the Cheshire FPGA reset/RTC generator: the reset
// FSM state encoding and helpers that size counters at elaboration time.
package cheshire_fpga_pkg;

    typedef enum logic [1:0] {
        RST_RESET = 2'd0,
        RST_HOLD  = 2'd1,
        RST_RUN   = 2'd2
    } rst_state_e;

    // Half period of the RTC square wave in clk_i cycles (floor). A zero
    // RTC frequency yields 0 so the caller's sanity check rejects it.
    function automatic int unsigned calc_half_per(input int unsigned clk_hz,
                                                  input int unsigned rtc_hz);
        if (rtc_hz == 32'd0) begin
            return 32'd0;
        end else begin
            return clk_hz / (32'd2 * rtc_hz);
        end
    endfunction

    // Bits needed for a counter running 0..n-1, never less than one.
    function automatic int unsigned cnt_width(input int unsigned n);
        if (n <= 32'd2) begin
            return 32'd1;
        end else begin
            return $clog2(n);
        end
    endfunction

endpackage

// File: rtl/cheshire_rtc_rst_gen_if.sv
// Board-side reset/RTC signal bundle of the Cheshire reset generator.
// master: the generator (drives resets and RTC); slave: the SoC/board side.
interface cheshire_rtc_rst_gen_if;
    logic ext_rst_req_i;
    logic soc_rst_no;
    logic rtc_o;
    logic rst_active_o;

    modport master (
        input  ext_rst_req_i,
        output soc_rst_no,
        output rtc_o,
        output rst_active_o
    );

    modport slave (
        output ext_rst_req_i,
        input  soc_rst_no,
        input  rtc_o,
        input  rst_active_o
    );
endinterface

// File: rtl/cheshire_rst_debounce.sv
// Level debounce filter for the synchronized reset request. The output only
// follows the input after DebounceCycles consecutive samples disagree with
// the current output; any agreeing sample restarts the count.
module cheshire_rst_debounce #(
    parameter int unsigned DebounceCycles = 32'd1024
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic req_i,
    output logic req_o
);
    import cheshire_fpga_pkg::*;

    localparam int unsigned CntW = cnt_width(DebounceCycles);
    localparam logic [CntW-1:0] CntLast = CntW'(DebounceCycles - 32'd1);

    logic [CntW-1:0] cnt_r;
    logic            filt_r;

    // Count consecutive differing samples; accept the new level on the last one
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_r  <= '0;
            filt_r <= 1'b0;
        end else if (req_i != filt_r) begin
            if (cnt_r == CntLast) begin
                cnt_r  <= '0;
                filt_r <= req_i;
            end else begin
                cnt_r  <= cnt_r + CntW'(1'b1);
            end
        end else begin
            cnt_r <= '0;
        end
    end

    assign req_o = filt_r;

endmodule

// File: rtl/cheshire_rtc_rst_gen.sv
// Cheshire FPGA reset and RTC generator.
// Produces a registered active-low SoC reset that is held for RstHoldCycles
// after every reset cause clears, plus a free-running RTC square wave.
// Optional feature: define CHESHIRE_RST_DEBOUNCE_EN to debounce the external
// reset request with cheshire_rst_debounce.
module cheshire_rtc_rst_gen #(
    parameter int unsigned ClkFreqHz      = 32'd50000000,
    parameter int unsigned RtcFreqHz      = 32'd1000000,
    parameter int unsigned RstHoldCycles  = 32'd64,
    parameter int unsigned DebounceCycles = 32'd1024
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    cheshire_rtc_rst_gen_if.master rst_if
);
    import cheshire_fpga_pkg::*;

    localparam int unsigned HalfPer = calc_half_per(ClkFreqHz, RtcFreqHz);
    localparam int unsigned RtcW    = cnt_width(HalfPer);
    localparam int unsigned HoldW   = cnt_width(RstHoldCycles);
    localparam logic [RtcW-1:0]  RtcLast  = RtcW'(HalfPer - 32'd1);
    localparam logic [HoldW-1:0] HoldLast = HoldW'(RstHoldCycles - 32'd1);

    if (HalfPer < 32'd1) begin : g_bad_half_per
        $error("cheshire_rtc_rst_gen: ClkFreqHz / (2*RtcFreqHz) must be >= 1");
    end
    if (RstHoldCycles < 32'd1) begin : g_bad_hold
        $error("cheshire_rtc_rst_gen: RstHoldCycles must be >= 1");
    end
    if (DebounceCycles < 32'd1) begin : g_bad_debounce
        $error("cheshire_rtc_rst_gen: DebounceCycles must be >= 1");
    end

    logic [RtcW-1:0]  rtc_cnt_r;
    logic             rtc_r;
    logic [1:0]       sync_r;
    logic             req_filt_s;
    rst_state_e       state_r;
    logic [HoldW-1:0] hold_cnt_r;
    logic             soc_rst_n_r;
    logic             rst_active_r;

    // RTC divider: free-running, cleared only by rst_i so the SoC time base
    // keeps ticking across SoC resets
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rtc_cnt_r <= '0;
            rtc_r     <= 1'b0;
        end else if (rtc_cnt_r == RtcLast) begin
            rtc_cnt_r <= '0;
            rtc_r     <= ~rtc_r;
        end else begin
            rtc_cnt_r <= rtc_cnt_r + RtcW'(1'b1);
        end
    end

    // Two-flop synchronizer for the asynchronous external reset request
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_r <= 2'b00;
        end else begin
            sync_r <= {sync_r[0], rst_if.ext_rst_req_i};
        end
    end

`ifdef CHESHIRE_RST_DEBOUNCE_EN
    cheshire_rst_debounce #(
        .DebounceCycles(DebounceCycles)
    ) i_rst_debounce (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .req_i (sync_r[1]),
        .req_o (req_filt_s)
    );
`else
    assign req_filt_s = sync_r[1];
`endif

    // Reset sequencer: hold the SoC in reset until the request has been
    // quiet for RstHoldCycles; a request always wins over leaving HOLD
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r      <= RST_RESET;
            hold_cnt_r   <= '0;
            soc_rst_n_r  <= 1'b0;
            rst_active_r <= 1'b1;
        end else begin
            case (state_r)
                RST_RESET: begin
                    state_r      <= RST_HOLD;
                    hold_cnt_r   <= '0;
                    soc_rst_n_r  <= 1'b0;
                    rst_active_r <= 1'b1;
                end
                RST_HOLD: begin
                    if (req_filt_s) begin
                        hold_cnt_r <= '0;
                    end else if (hold_cnt_r == HoldLast) begin
                        state_r      <= RST_RUN;
                        hold_cnt_r   <= '0;
                        soc_rst_n_r  <= 1'b1;
                        rst_active_r <= 1'b0;
                    end else begin
                        hold_cnt_r <= hold_cnt_r + HoldW'(1'b1);
                    end
                end
                RST_RUN: begin
                    if (req_filt_s) begin
                        state_r      <= RST_HOLD;
                        hold_cnt_r   <= '0;
                        soc_rst_n_r  <= 1'b0;
                        rst_active_r <= 1'b1;
                    end else begin
                        hold_cnt_r <= '0;
                    end
                end
                default: begin
                    state_r      <= RST_RESET;
                    hold_cnt_r   <= '0;
                    soc_rst_n_r  <= 1'b0;
                    rst_active_r <= 1'b1;
                end
            endcase
        end
    end

    assign rst_if.soc_rst_no   = soc_rst_n_r;
    assign rst_if.rst_active_o = rst_active_r;
    assign rst_if.rtc_o        = rtc_r;

endmodule

// File: tb/tb_cheshire_rtc_rst_gen.sv
// Directed bench for cheshire_rtc_rst_gen with ClkFreqHz=8, RtcFreqHz=1
// (RTC half period 4), RstHoldCycles=4, DebounceCycles=8. Expectations for
// the request-dependent parts follow CHESHIRE_RST_DEBOUNCE_EN.
module tb_cheshire_rtc_rst_gen;

    localparam int NVEC = 40;

    typedef struct {
        logic req;
        logic soc;
        logic rtc;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    vec_t tbl [NVEC];
    int   n_checks = 0;
    int   n_fail   = 0;

    cheshire_rtc_rst_gen_if rst_if ();

    cheshire_rtc_rst_gen #(
        .ClkFreqHz      (8),
        .RtcFreqHz      (1),
        .RstHoldCycles  (4),
        .DebounceCycles (8)
    ) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .rst_if (rst_if)
    );

    always #5 clk = ~clk;

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check_bit({tag, "_soc_rst_no"},   rst_if.soc_rst_no,   1'b0);
        check_bit({tag, "_rst_active_o"}, rst_if.rst_active_o, 1'b1);
        check_bit({tag, "_rtc_o"},        rst_if.rtc_o,        1'b0);
    endtask

    // Run n clock edges, sampling at each falling edge; report the first edge
    // index (1-based) at which soc_rst_no / rtc_o equal the given levels, -1 if never.
    task automatic watch(input int n, input logic soc_lvl, input logic rtc_lvl,
                         output int k_soc, output int k_rtc);
        k_soc = -1;
        k_rtc = -1;
        for (int k = 1; k <= n; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k_soc < 0 && rst_if.soc_rst_no === soc_lvl) k_soc = k;
            if (k_rtc < 0 && rst_if.rtc_o === rtc_lvl) k_rtc = k;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k_a;
        int k_b;
        int k_c;
        int k_d;
        int dummy;

        // Entry i: request applied after edge i, outputs expected after edge i,
        // edges counted from the last edge that saw rst_i high.
        // Default: RUN at edge 5; a 1-cycle pulse drives reset at edge 13;
        // a second pulse lands on the HOLD->RUN edge 17, so RUN only at 21.
        for (int i = 0; i < NVEC; i++) begin
            tbl[i].req = (i == 10) || (i == 14);
            tbl[i].rtc = (((i / 4) % 2) == 1);
`ifdef CHESHIRE_RST_DEBOUNCE_EN
            tbl[i].soc = (i >= 5);
`else
            tbl[i].soc = ((i >= 5) && (i <= 12)) || (i >= 21);
`endif
        end

        rst_if.ext_rst_req_i = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_vals("in_reset");

        @(posedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            rst_if.ext_rst_req_i = tbl[i].req;
            @(negedge clk);
            check_bit($sformatf("vec%0d_soc_rst_no", i),   rst_if.soc_rst_no,   tbl[i].soc);
            check_bit($sformatf("vec%0d_rst_active_o", i), rst_if.rst_active_o, ~tbl[i].soc);
            check_bit($sformatf("vec%0d_rtc_o", i),        rst_if.rtc_o,        tbl[i].rtc);
            @(posedge clk);
            #1;
        end

        // Request held for 20 cycles while running
        rst_if.ext_rst_req_i = 1'b1;
        watch(20, 1'b0, 1'b0, k_a, dummy);
        rst_if.ext_rst_req_i = 1'b0;
        watch(20, 1'b1, 1'b1, k_b, dummy);
`ifdef CHESHIRE_RST_DEBOUNCE_EN
        check_int("hold20_fall_latency", k_a, 11);
        check_int("hold20_rise_latency", k_b, 14);

        // Short pulses split by a single quiet sample never pass the filter
        rst_if.ext_rst_req_i = 1'b1;
        watch(5, 1'b0, 1'b0, k_a, dummy);
        rst_if.ext_rst_req_i = 1'b0;
        watch(1, 1'b0, 1'b0, k_b, dummy);
        rst_if.ext_rst_req_i = 1'b1;
        watch(5, 1'b0, 1'b0, k_c, dummy);
        rst_if.ext_rst_req_i = 1'b0;
        watch(20, 1'b0, 1'b0, k_d, dummy);
        check_int("pulse5_a_no_reset", k_a, -1);
        check_int("pulse_gap_no_reset", k_b, -1);
        check_int("pulse5_b_no_reset", k_c, -1);
        check_int("pulse_tail_no_reset", k_d, -1);
`else
        check_int("hold20_fall_latency", k_a, 3);
        check_int("hold20_rise_latency", k_b, 6);
`endif

        // Asynchronous reset while running
        check_bit("run_before_rst_soc", rst_if.soc_rst_no, 1'b1);
        #2 rst = 1'b1;
        #1 check_reset_vals("async_in_run");
        @(posedge clk);
        #1 rst = 1'b0;

        // One-cycle rst_i pulse mid-HOLD, right after rtc_o has risen
        repeat (4) @(posedge clk);
        @(negedge clk);
        check_bit("mid_hold_rtc_high", rst_if.rtc_o, 1'b1);
        check_bit("mid_hold_soc_low",  rst_if.soc_rst_no, 1'b0);
        #2 rst = 1'b1;
        #1 check_reset_vals("async_mid_hold");
        @(posedge clk);
        #1 rst = 1'b0;
        watch(10, 1'b1, 1'b1, k_a, k_b);
        check_int("restart_soc_release_edge", k_a, 5);
        check_int("restart_rtc_first_rise",   k_b, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
